// File: rtl/gt_pattern_player_pkg.sv
// Shared types for the GT pattern player: FSM encoding, run-mode constants
// and the skid-buffer admission rule used to gate RAM reads.
package gt_pattern_player_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic MODE_CONT  = 1'b0;
  localparam logic MODE_BURST = 1'b1;

  // A read may be issued only if, after this cycle's pop, the buffered words
  // plus the one already in flight leave a free slot for the new read.
  function automatic logic buf_has_room(input logic vld0, input logic vld1,
                                        input logic inflight, input logic pop);
    logic [1:0] occ;
    occ = 2'(vld0) + 2'(vld1) + 2'(inflight) - 2'(pop);
    return occ < 2'd2;
  endfunction

endpackage

// File: rtl/gt_pattern_sdpram.sv
// Single-clock simple-dual-port pattern RAM: 1-cycle registered read, read-first
// on same-address collision, no backpressure (caller gates rd_en_i).
module gt_pattern_sdpram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/gt_pattern_player.sv
// RAM-backed AXI-Stream pattern player for one GT lane; first beat two cycles
// after start, then one beat per cycle while gt_tready is high; stalls hold output.
module gt_pattern_player #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              gt_clk,
  input  logic              gt_rstb,
  input  logic              ram_we,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_data,
  input  logic [ADDR_W-1:0] cfg_last,
  input  logic              cfg_burst,
  input  logic [CNT_W-1:0]  cfg_passes,
  input  logic              gt_start,
  input  logic              gt_reset,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] gt_tdata,
  output logic              gt_tvalid,
  output logic              gt_tlast,
  input  logic              gt_tready
);

  import gt_pattern_player_pkg::*;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  pass_q, pass_d;
  logic [ADDR_W-1:0] last_q;
  logic              burst_q;
  logic [CNT_W-1:0]  passes_q;
  logic              rd_vld_q, rd_last_q;
  logic              vld0_q, vld1_q, last0_q, last1_q;
  logic [DATA_W-1:0] dat0_q, dat1_q;
  logic              busy_q, done_q;
  logic [DATA_W-1:0] ram_rdata;

  logic              start_acc, pop, room, issue, at_last, final_issue;
  logic [ADDR_W-1:0] last_eff;
  logic              burst_eff;
  logic [CNT_W-1:0]  passes_eff;

  gt_pattern_sdpram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i     (gt_clk),
    .wr_en_i   (ram_we),
    .wr_addr_i (ram_addr),
    .wr_data_i (ram_data),
    .rd_en_i   (issue),
    .rd_addr_i (addr_q),
    .rd_data_o (ram_rdata)
  );

  // The first read goes out in the start cycle itself, so the live cfg inputs
  // stand in for the not-yet-latched copies during that one cycle.
  always_comb begin
    start_acc   = gt_start && !gt_reset && (state_q == ST_IDLE);
    last_eff    = start_acc ? cfg_last   : last_q;
    burst_eff   = start_acc ? cfg_burst  : burst_q;
    passes_eff  = start_acc ? cfg_passes : passes_q;
    pop         = vld0_q && gt_tready;
    room        = buf_has_room(vld0_q, vld1_q, rd_vld_q, pop);
    issue       = !gt_reset && (start_acc || state_q == ST_RUN) && room;
    at_last     = (addr_q == last_eff);
    final_issue = issue && at_last && (burst_eff == MODE_BURST) && (pass_q == passes_eff);
    addr_d      = addr_q;
    pass_d      = pass_q;
    if (issue) begin
      if (at_last) begin
        addr_d = '0;
        pass_d = final_issue ? '0 : pass_q + CNT_W'(1);
      end else begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge gt_clk or negedge gt_rstb) begin
    if (!gt_rstb) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      pass_q    <= '0;
      last_q    <= '0;
      burst_q   <= MODE_CONT;
      passes_q  <= '0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
      vld0_q    <= 1'b0;
      vld1_q    <= 1'b0;
      last0_q   <= 1'b0;
      last1_q   <= 1'b0;
      dat0_q    <= '0;
      dat1_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (gt_reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      pass_q    <= '0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
      vld0_q    <= 1'b0;
      vld1_q    <= 1'b0;
      last0_q   <= 1'b0;
      last1_q   <= 1'b0;
      dat0_q    <= '0;
      dat1_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      addr_q    <= addr_d;
      pass_q    <= pass_d;
      rd_vld_q  <= issue;
      rd_last_q <= at_last;

      // Skid buffer: entry 0 drives the stream, entry 1 catches the in-flight
      // read that lands while entry 0 is stalled.
      if (rd_vld_q && pop) begin
        if (vld1_q) begin
          dat0_q  <= dat1_q;
          last0_q <= last1_q;
          dat1_q  <= ram_rdata;
          last1_q <= rd_last_q;
        end else begin
          dat0_q  <= ram_rdata;
          last0_q <= rd_last_q;
        end
      end else if (rd_vld_q) begin
        if (!vld0_q) begin
          dat0_q  <= ram_rdata;
          last0_q <= rd_last_q;
          vld0_q  <= 1'b1;
        end else begin
          dat1_q  <= ram_rdata;
          last1_q <= rd_last_q;
          vld1_q  <= 1'b1;
        end
      end else if (pop) begin
        if (vld1_q) begin
          dat0_q  <= dat1_q;
          last0_q <= last1_q;
          vld1_q  <= 1'b0;
        end else begin
          vld0_q  <= 1'b0;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (start_acc) begin
            last_q   <= cfg_last;
            burst_q  <= cfg_burst;
            passes_q <= cfg_passes;
            busy_q   <= 1'b1;
            state_q  <= final_issue ? ST_DRAIN : ST_RUN;
          end
        end
        ST_RUN: begin
          if (final_issue) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Nothing in flight and only the head word left: this pop is the final beat.
          if (pop && !vld1_q && !rd_vld_q) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign gt_tdata  = dat0_q;
  assign gt_tvalid = vld0_q;
  assign gt_tlast  = last0_q;

endmodule

// File: tb/tb_gt_pattern_player.sv
// Randomised bench for gt_pattern_player against a pattern-array/queue model.
module tb_gt_pattern_player;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = 16;

  logic              gt_clk;
  logic              gt_rstb;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic [ADDR_W-1:0] cfg_last;
  logic              cfg_burst;
  logic [CNT_W-1:0]  cfg_passes;
  logic              gt_start;
  logic              gt_reset;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] gt_tdata;
  logic              gt_tvalid;
  logic              gt_tlast;
  logic              gt_tready;

  gt_pattern_player #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) dut (
    .gt_clk     (gt_clk),
    .gt_rstb    (gt_rstb),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .cfg_last   (cfg_last),
    .cfg_burst  (cfg_burst),
    .cfg_passes (cfg_passes),
    .gt_start   (gt_start),
    .gt_reset   (gt_reset),
    .busy       (busy),
    .done       (done),
    .gt_tdata   (gt_tdata),
    .gt_tvalid  (gt_tvalid),
    .gt_tlast   (gt_tlast),
    .gt_tready  (gt_tready)
  );

  initial gt_clk = 1'b0;
  always #5 gt_clk = ~gt_clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: pattern contents and the expected beat list {tlast, tdata}.
  logic [DATA_W-1:0] pat [256];
  logic [DATA_W:0]   exp_q [$];
  logic [DATA_W:0]   got_q [$];
  int first_vld, last_hs, done_cyc, done_cnt, gap_cnt;
  logic busy_at_done;

  task automatic tick();
    @(posedge gt_clk);
    #1;
  endtask

  task automatic ram_write(input int a, input logic [DATA_W-1:0] d);
    ram_we = 1'b1; ram_addr = ADDR_W'(a); ram_data = d;
    tick();
    ram_we = 1'b0;
    pat[a] = d;
  endtask

  task automatic start_run(input int last, input bit burst, input int passes);
    cfg_last = ADDR_W'(last); cfg_burst = burst; cfg_passes = CNT_W'(passes);
    gt_start = 1'b1;
    tick();
    gt_start = 1'b0;
  endtask

  task automatic build_exp(input int last, input int npass);
    exp_q.delete();
    for (int p = 0; p < npass; p++)
      for (int i = 0; i <= last; i++)
        exp_q.push_back({(i == last), pat[i]});
  endtask

  // Drives tready and optional start/reset pulses, records handshaken beats.
  task automatic collect(input int ncyc, input int ready_pct, input bit stop_on_done,
                         input int start_at, input int reset_at);
    got_q.delete();
    first_vld = -1; last_hs = -1; done_cyc = -1; done_cnt = 0; gap_cnt = 0; busy_at_done = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      if (done) begin done_cnt++; done_cyc = c; busy_at_done = busy; end
      if (done && stop_on_done) break;
      gt_start  = (c == start_at);
      gt_reset  = (c == reset_at);
      gt_tready = ($urandom_range(0, 99) < ready_pct);
      if (gt_tvalid && first_vld < 0) first_vld = c;
      if (first_vld >= 0 && !gt_tvalid) gap_cnt++;
      if (gt_tvalid && gt_tready) begin
        got_q.push_back({gt_tlast, gt_tdata});
        last_hs = c;
      end
      tick();
    end
    gt_start = 1'b0;
    gt_reset = 1'b0;
  endtask

  task automatic test_reset();
    gt_rstb = 1'b0;
    tick();
    n_total++; if (gt_tvalid !== 1'b0) $display("FAIL rst_tvalid_async got=%b exp=0", gt_tvalid); else n_pass++;
    gt_rstb = 1'b1;
    tick();
    n_total++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL rst_done got=%b exp=0", done); else n_pass++;
    n_total++; if (gt_tvalid !== 1'b0) $display("FAIL rst_tvalid got=%b exp=0", gt_tvalid); else n_pass++;
    n_total++; if (gt_tlast !== 1'b0) $display("FAIL rst_tlast got=%b exp=0", gt_tlast); else n_pass++;
    n_total++; if (gt_tdata !== '0) $display("FAIL rst_tdata got=%h exp=0", gt_tdata); else n_pass++;
  endtask

  task automatic test_burst_basic();
    for (int i = 0; i < 8; i++) ram_write(i, DATA_W'(i));
    start_run(7, 1'b1, 1);
    n_total++; if (gt_tvalid !== 1'b0) $display("FAIL basic_tvalid_start1 got=%b exp=0", gt_tvalid); else n_pass++;
    collect(100, 100, 1'b1, -1, -1);
    build_exp(7, 2);
    n_total++; if (first_vld !== 1) $display("FAIL basic_first_beat got=%0d exp=1", first_vld); else n_pass++;
    n_total++; if (got_q.size() !== 16) $display("FAIL basic_beats got=%0d exp=16", got_q.size()); else n_pass++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_total++;
      if (got_q[i] !== exp_q[i]) $display("FAIL basic_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); else n_pass++;
    end
    n_total++; if (done_cnt !== 1) $display("FAIL basic_done_cnt got=%0d exp=1", done_cnt); else n_pass++;
    n_total++; if (done_cyc !== last_hs + 1) $display("FAIL basic_done_time got=%0d exp=%0d", done_cyc, last_hs + 1); else n_pass++;
    n_total++; if (busy_at_done !== 1'b0) $display("FAIL basic_busy_at_done got=%b exp=0", busy_at_done); else n_pass++;
  endtask

  task automatic test_continuous();
    start_run(3, 1'b0, 0);
    collect(60, 100, 1'b0, -1, -1);
    n_total++; if (first_vld !== 1) $display("FAIL cont_first_beat got=%0d exp=1", first_vld); else n_pass++;
    n_total++; if (gap_cnt !== 0) $display("FAIL cont_gaps got=%0d exp=0", gap_cnt); else n_pass++;
    n_total++; if (got_q.size() !== 59) $display("FAIL cont_beats got=%0d exp=59", got_q.size()); else n_pass++;
    for (int i = 0; i < got_q.size(); i++) begin
      n_total++;
      if (got_q[i] !== {((i % 4) == 3), pat[i % 4]})
        $display("FAIL cont_beat%0d got=%h exp=%h", i, got_q[i], {((i % 4) == 3), pat[i % 4]});
      else n_pass++;
    end
    gt_reset = 1'b1;
    tick();
    gt_reset = 1'b0;
    n_total++; if (gt_tvalid !== 1'b0) $display("FAIL cont_abort_tvalid got=%b exp=0", gt_tvalid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL cont_abort_busy got=%b exp=0", busy); else n_pass++;
    collect(10, 100, 1'b0, -1, -1);
    n_total++; if (got_q.size() !== 0) $display("FAIL cont_after_abort_beats got=%0d exp=0", got_q.size()); else n_pass++;
    n_total++; if (done_cnt !== 0) $display("FAIL cont_abort_done got=%0d exp=0", done_cnt); else n_pass++;
  endtask

  task automatic test_random_ready();
    logic [DATA_W:0] prev;
    bit prev_vld, prev_rdy, fin;
    for (int i = 0; i < 6; i++) ram_write(i, DATA_W'($urandom));
    build_exp(5, 1);
    start_run(5, 1'b1, 0);
    got_q.delete();
    prev_vld = 0; prev_rdy = 0; prev = '0; fin = 0;
    for (int c = 0; c < 400 && !fin; c++) begin
      if (done) fin = 1;
      else begin
        if (prev_vld && !prev_rdy) begin
          n_total++;
          if (gt_tvalid !== 1'b1 || {gt_tlast, gt_tdata} !== prev)
            $display("FAIL rnd_stall_hold c=%0d got=%b/%h exp=1/%h", c, gt_tvalid, {gt_tlast, gt_tdata}, prev);
          else n_pass++;
        end
        gt_tready = 1'($urandom_range(0, 1));
        if (gt_tvalid && gt_tready) got_q.push_back({gt_tlast, gt_tdata});
        prev_vld = gt_tvalid; prev_rdy = gt_tready; prev = {gt_tlast, gt_tdata};
        tick();
      end
    end
    n_total++; if (!fin) $display("FAIL rnd_done got=0 exp=1"); else n_pass++;
    n_total++; if (got_q.size() !== 6) $display("FAIL rnd_beats got=%0d exp=6", got_q.size()); else n_pass++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_total++;
      if (got_q[i] !== exp_q[i]) $display("FAIL rnd_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_last_zero();
    build_exp(0, 4);
    start_run(0, 1'b1, 3);
    collect(60, 100, 1'b1, -1, -1);
    n_total++; if (got_q.size() !== 4) $display("FAIL lz_beats got=%0d exp=4", got_q.size()); else n_pass++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_total++;
      if (got_q[i] !== exp_q[i]) $display("FAIL lz_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); else n_pass++;
    end
    n_total++; if (done_cnt !== 1 || done_cyc !== last_hs + 1)
      $display("FAIL lz_done cnt=%0d at=%0d exp cnt=1 at=%0d", done_cnt, done_cyc, last_hs + 1);
    else n_pass++;
  endtask

  task automatic test_random_cfg();
    int last, passes;
    for (int it = 0; it < 3; it++) begin
      last   = $urandom_range(0, 11);
      passes = $urandom_range(0, 2);
      for (int i = 0; i <= last; i++) ram_write(i, DATA_W'($urandom));
      build_exp(last, passes + 1);
      start_run(last, 1'b1, passes);
      collect(500, 70, 1'b1, -1, -1);
      n_total++;
      if (got_q.size() !== exp_q.size()) $display("FAIL rcfg%0d_beats got=%0d exp=%0d", it, got_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        n_total++;
        if (got_q[i] !== exp_q[i]) $display("FAIL rcfg%0d_beat%0d got=%h exp=%h", it, i, got_q[i], exp_q[i]); else n_pass++;
      end
      n_total++; if (done_cnt !== 1) $display("FAIL rcfg%0d_done got=%0d exp=1", it, done_cnt); else n_pass++;
    end
  endtask

  task automatic test_start_ignored();
    for (int i = 0; i < 8; i++) ram_write(i, DATA_W'(i));
    build_exp(7, 2);
    start_run(7, 1'b1, 1);
    cfg_last = ADDR_W'(2); cfg_burst = 1'b0; cfg_passes = CNT_W'(5);
    collect(100, 100, 1'b1, 5, -1);
    n_total++; if (got_q.size() !== 16) $display("FAIL ign_beats got=%0d exp=16", got_q.size()); else n_pass++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_total++;
      if (got_q[i] !== exp_q[i]) $display("FAIL ign_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); else n_pass++;
    end
    cfg_last = ADDR_W'(7); cfg_burst = 1'b1; cfg_passes = CNT_W'(1);
    gt_start = 1'b1; gt_reset = 1'b1;
    tick();
    gt_start = 1'b0; gt_reset = 1'b0;
    n_total++; if (busy !== 1'b0) $display("FAIL startrst_busy got=%b exp=0", busy); else n_pass++;
    collect(10, 100, 1'b0, -1, -1);
    n_total++; if (got_q.size() !== 0) $display("FAIL startrst_beats got=%0d exp=0", got_q.size()); else n_pass++;
    start_run(7, 1'b1, 1);
    collect(20, 100, 1'b0, -1, 6);
    n_total++; if (got_q.size() !== 6) $display("FAIL midrst_beats got=%0d exp=6", got_q.size()); else n_pass++;
    n_total++; if (done_cnt !== 0) $display("FAIL midrst_done got=%0d exp=0", done_cnt); else n_pass++;
    start_run(7, 1'b1, 1);
    collect(100, 100, 1'b1, -1, -1);
    n_total++; if (got_q.size() !== 16) $display("FAIL replay_beats got=%0d exp=16", got_q.size()); else n_pass++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_total++;
      if (got_q[i] !== exp_q[i]) $display("FAIL replay_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_overwrite();
    int gaps, pos;
    bit seen_new;
    logic [DATA_W-1:0] old2;
    logic [DATA_W:0] nw, od;
    old2 = pat[2];
    start_run(7, 1'b0, 0);
    got_q.delete();
    gaps = 0;
    for (int c = 0; c < 80; c++) begin
      gt_tready = 1'b1;
      ram_we = (c == 20); ram_addr = ADDR_W'(2); ram_data = 32'hA5A5_A5A5;
      if (c >= 1 && !gt_tvalid) gaps++;
      if (gt_tvalid) got_q.push_back({gt_tlast, gt_tdata});
      tick();
    end
    ram_we = 1'b0;
    pat[2] = 32'hA5A5_A5A5;
    gt_reset = 1'b1;
    tick();
    gt_reset = 1'b0;
    n_total++; if (gaps !== 0) $display("FAIL ovw_gaps got=%0d exp=0", gaps); else n_pass++;
    nw = {1'b0, pat[2]};
    od = {1'b0, old2};
    seen_new = 0;
    for (int i = 0; i < got_q.size(); i++) begin
      pos = i % 8;
      n_total++;
      if (pos != 2) begin
        if (got_q[i] !== {(pos == 7), pat[pos]}) $display("FAIL ovw_beat%0d got=%h exp=%h", i, got_q[i], {(pos == 7), pat[pos]});
        else n_pass++;
      end else begin
        if (got_q[i] === nw) begin
          seen_new = 1; n_pass++;
        end else if (!seen_new && got_q[i] === od) n_pass++;
        else $display("FAIL ovw_pos2_beat%0d got=%h exp=%h", i, got_q[i], seen_new ? nw : od);
      end
    end
    n_total++; if (!seen_new) $display("FAIL ovw_new_seen got=0 exp=1"); else n_pass++;
  endtask

  initial begin
    gt_rstb = 1'b0; ram_we = 1'b0; ram_addr = '0; ram_data = '0;
    cfg_last = '0; cfg_burst = 1'b0; cfg_passes = '0;
    gt_start = 1'b0; gt_reset = 1'b0; gt_tready = 1'b0;
    tick();
    test_reset();
    test_burst_basic();
    test_continuous();
    test_random_ready();
    test_last_zero();
    test_random_cfg();
    test_start_ignored();
    test_overwrite();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
